// File: rtl/demux_regbank.sv
// demux_regbank: write side of a 32-word register bank with burst pointer and clear sweep.
// Optional DEMUX_REG0_ZERO_EN hardwires word 0 to zero (writes to address 0 are dropped).
module demux_regbank #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     WrValid,
    output logic                     WrReady,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [WIDTH-1:0]         WrData,
    input  logic                     Burst,
    input  logic                     PtrLoad,
    input  logic                     Clear,
    output logic                     Busy,
    output logic [ADDR_W-1:0]        Ptr,
    output logic [WIDTH*DEPTH-1:0]   Out
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t             state;
    logic [ADDR_W-1:0]  clr_idx;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               fire;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  waddr;
    logic               wr_ok;

    assign WrReady = (state == IDLE) && !Clear;
    assign Busy    = (state == CLEAR);
    assign fire    = WrValid && WrReady;

    // A same-cycle PtrLoad redefines the burst origin.
    assign base  = PtrLoad ? WrAddr : Ptr;
    assign waddr = Burst ? base : WrAddr;

`ifdef DEMUX_REG0_ZERO_EN
    assign wr_ok = (waddr != '0);
`else
    assign wr_ok = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            Ptr     <= '0;
            clr_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (Clear) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end else begin
                        if (fire && Burst) begin
                            Ptr <= base + ONE;
                        end else if (PtrLoad) begin
                            Ptr <= WrAddr;
                        end
                        if (fire && wr_ok) begin
                            mem[waddr] <= WrData;
                        end
                    end
                end
                CLEAR: begin
                    mem[clr_idx] <= '0;
                    clr_idx      <= clr_idx + ONE;
                    if (clr_idx == LAST) begin
                        state <= IDLE;
                        Ptr   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign Out[WIDTH*g +: WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_demux_regbank.sv
// Scoreboard bench for demux_regbank: directed scenarios plus random traffic
// checked against an array-based bank model.
module tb_demux_regbank;

    localparam int W = 32;
    localparam int D = 32;
    localparam int A = 5;

`ifdef DEMUX_REG0_ZERO_EN
    localparam bit ZERO0 = 1'b1;
`else
    localparam bit ZERO0 = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             WrValid = 1'b0;
    logic             WrReady;
    logic [A-1:0]     WrAddr = '0;
    logic [W-1:0]     WrData = '0;
    logic             Burst = 1'b0;
    logic             PtrLoad = 1'b0;
    logic             Clear = 1'b0;
    logic             Busy;
    logic [A-1:0]     Ptr;
    logic [W*D-1:0]   Out;

    demux_regbank #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
        .Clk(Clk), .Reset(Reset), .WrValid(WrValid), .WrReady(WrReady),
        .WrAddr(WrAddr), .WrData(WrData), .Burst(Burst), .PtrLoad(PtrLoad),
        .Clear(Clear), .Busy(Busy), .Ptr(Ptr), .Out(Out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W*D-1:0] out;
        logic [A-1:0]   ptr;
        logic           busy;
        logic           rdy;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    // Reference model: plain array of words, a pointer, and a remaining-sweep count.
    logic [W-1:0] m [D];
    int mptr = 0;
    int left = 0;
    int nxt = 0;

    task automatic cyc(input bit r, input bit wv, input int a,
                       input logic [W-1:0] d, input bit b,
                       input bit pl, input bit c);
        exp_t e;
        int t;
        @(negedge Clk);
        Reset = r; WrValid = wv; WrAddr = A'(a); WrData = d;
        Burst = b; PtrLoad = pl; Clear = c;
        e.rdy = (left == 0) && !c;
        if (r) begin
            for (int i = 0; i < D; i++) m[i] = '0;
            mptr = 0; left = 0;
        end else if (left > 0) begin
            m[nxt] = '0;
            nxt++;
            left--;
            if (left == 0) mptr = 0;
        end else if (c) begin
            left = D; nxt = 0;
        end else begin
            if (wv) begin
                t = b ? (pl ? a : mptr) : a;
                if (!(ZERO0 && t == 0)) m[t] = d;
                if (b) mptr = (t + 1) % D;
                else if (pl) mptr = a;
            end else if (pl) begin
                mptr = a;
            end
        end
        for (int i = 0; i < D; i++) e.out[W*i +: W] = m[i];
        e.ptr = A'(mptr);
        e.busy = (left > 0);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, 0, 0);
    endtask

    // Monitor: WrReady sampled at the edge it governs, registered outputs #1 later.
    initial begin
        exp_t e;
        logic rdy;
        int bad;
        forever begin
            @(posedge Clk);
            if (q.size() != 0) begin
                rdy = WrReady;
                #1;
                e = q.pop_front();
                checks++;
                if (rdy === e.rdy) passed++;
                else $display("FAIL wrready act=%b exp=%b t=%0t", rdy, e.rdy, $time);
                checks++;
                if (Busy === e.busy) passed++;
                else $display("FAIL busy act=%b exp=%b t=%0t", Busy, e.busy, $time);
                checks++;
                if (Ptr === e.ptr) passed++;
                else $display("FAIL ptr act=%0d exp=%0d t=%0t", Ptr, e.ptr, $time);
                checks++;
                if (Out === e.out) passed++;
                else begin
                    bad = 0;
                    for (int i = D - 1; i >= 0; i--)
                        if (Out[W*i +: W] !== e.out[W*i +: W]) bad = i;
                    $display("FAIL out word%0d act=%h exp=%h t=%0t", bad,
                             Out[W*bad +: W], e.out[W*bad +: W], $time);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < D; i++) m[i] = '0;
        cyc(1, 0, 0, '0, 0, 0, 0);
        cyc(1, 0, 0, '0, 0, 0, 0);
        idle(2);
        // direct write to top word
        cyc(0, 1, 31, 32'hDEADBEEF, 0, 0, 0);
        idle(1);
        // burst with wrap from 30
        cyc(0, 0, 30, '0, 0, 1, 0);
        cyc(0, 1, 0, 32'h1, 1, 0, 0);
        cyc(0, 1, 0, 32'h2, 1, 0, 0);
        cyc(0, 1, 0, 32'h3, 1, 0, 0);
        idle(1);
        // fill, then clear with writes held during the sweep
        for (int i = 0; i < D; i++) cyc(0, 1, i, 32'hFFFFFFFF, 0, 0, 0);
        cyc(0, 1, 9, 32'hA5A5A5A5, 0, 0, 1);
        for (int i = 0; i < D; i++) cyc(0, 1, i, 32'hA5A5A5A5, 0, 0, i == 4);
        idle(2);
        // clear/write collision on word 5
        cyc(0, 1, 5, 32'h12345678, 0, 0, 1);
        idle(D + 1);
        // reset at sweep cycle 10, then write word 7
        for (int i = 0; i < D; i++) cyc(0, 1, i, 32'h0F0F0000 + i, 0, 0, 0);
        cyc(0, 0, 0, '0, 0, 0, 1);
        idle(10);
        cyc(1, 0, 0, '0, 0, 0, 0);
        cyc(0, 1, 7, 32'hCAFEF00D, 0, 0, 0);
        idle(2);
        // random traffic, with PtrLoad/Burst combinations and a burst over word 0
        cyc(0, 1, 31, 32'h77, 1, 1, 0);
        cyc(0, 1, 3, 32'h88, 1, 0, 0);
        cyc(0, 1, 12, 32'h99, 0, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                int'($urandom_range(0, D - 1)), $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                $urandom_range(0, 59) == 0);
        end
        idle(2);
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain act=%0d exp=0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
